// File: rtl/mux_scan_ctrl_if.sv
// rtl/mux_scan_ctrl_if.sv - scan controller bundle: mux select/sense side and word handshake side.
// Optional parity line is present only when MUX_SCAN_PARITY_EN is defined.
interface mux_scan_ctrl_if;
  logic       start;
  logic       cont;
  logic       O0;
  logic       ready;
  logic [1:0] S;
  logic [3:0] data;
  logic       valid;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;

  modport master (input start, cont, O0, ready, output S, data, valid, busy, parity);
  modport slave  (output start, cont, O0, ready, input S, data, valid, busy, parity);
`else
  modport master (input start, cont, O0, ready, output S, data, valid, busy);
  modport slave  (output start, cont, O0, ready, input S, data, valid, busy);
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - walks a 4:1 mux select, samples O0 per leg and presents the 4-bit word.
// Optional MUX_SCAN_PARITY_EN adds a registered XOR of the captured word.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  mux_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_HOLD} state_e;

  localparam logic [2:0] SETTLE_CNT = 3'(SETTLE);
  // With no settle time every select leg goes straight to its sampling cycle.
  localparam state_e SCAN_ENTRY = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

  state_e     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] data_q, data_d;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sel_q    <= 2'd0;
      cnt_q    <= 3'd0;
      data_q   <= 4'd0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sel_d   = 2'd0;
          cnt_d   = SETTLE_CNT;
          state_d = SCAN_ENTRY;
        end
      end
      ST_SETTLE: begin
        cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        data_d[sel_q] = bus.O0;
        if (sel_q == 2'd3) begin
          state_d  = ST_HOLD;
`ifdef MUX_SCAN_PARITY_EN
          parity_d = ^data_d;
`endif
        end else begin
          sel_d   = sel_q + 2'd1;
          cnt_d   = SETTLE_CNT;
          state_d = SCAN_ENTRY;
        end
      end
      ST_HOLD: begin
        // start is deliberately not looked at here; only the handshake leaves HOLD.
        if (bus.ready) begin
          sel_d = 2'd0;
          if (bus.cont) begin
            cnt_d   = SETTLE_CNT;
            state_d = SCAN_ENTRY;
          end else begin
            cnt_d   = 3'd0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.S      = sel_q;
    bus.data   = data_q;
    bus.valid  = (state_q == ST_HOLD);
    bus.busy   = (state_q != ST_IDLE);
`ifdef MUX_SCAN_PARITY_EN
    bus.parity = parity_q;
`endif
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - randomized bench for mux_scan_ctrl at SETTLE=0 and SETTLE=2.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  mux_scan_ctrl_if if0 ();
  mux_scan_ctrl_if if2 ();

  logic       start_v [2];
  logic       cont_v  [2];
  logic       ready_v [2];
  logic       o0_v    [2];
  logic [3:0] word_v  [2];
  logic [3:0] prev_w  [2];

  logic [1:0] s_w     [2];
  logic [3:0] data_w  [2];
  logic       valid_w [2];
  logic       busy_w  [2];

  assign if0.start = start_v[0];
  assign if0.cont  = cont_v[0];
  assign if0.ready = ready_v[0];
  assign if0.O0    = o0_v[0];
  assign if2.start = start_v[1];
  assign if2.cont  = cont_v[1];
  assign if2.ready = ready_v[1];
  assign if2.O0    = o0_v[1];

  assign s_w[0] = if0.S;  assign data_w[0] = if0.data;  assign valid_w[0] = if0.valid;  assign busy_w[0] = if0.busy;
  assign s_w[1] = if2.S;  assign data_w[1] = if2.data;  assign valid_w[1] = if2.valid;  assign busy_w[1] = if2.busy;

`ifdef MUX_SCAN_PARITY_EN
  logic parity_w [2];
  assign parity_w[0] = if0.parity;
  assign parity_w[1] = if2.parity;
`endif

  mux_scan_ctrl #(.SETTLE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  mux_scan_ctrl #(.SETTLE(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  function automatic int st(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Downstream mux model: O0 = word[S], inverted during the first SETTLE cycles after S moves.
  int   age    [2];
  logic prev_s_busy [2];
  logic [1:0] prev_s [2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (s_w[d] != prev_s[d] || !prev_s_busy[d]) age[d] = 0;
      else age[d] = age[d] + 1;
      prev_s[d]      = s_w[d];
      prev_s_busy[d] = busy_w[d];
      o0_v[d] = (age[d] < st(d)) ? ~word_v[d][s_w[d]] : word_v[d][s_w[d]];
    end
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_scan(int d, logic [3:0] w);
    word_v[d]  = w;
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
  endtask

  // Entered at the first negedge after the edge that launched the scan.
  task automatic scan_result(int d, logic [3:0] w, logic [3:0] prev);
    int n = 0;
    int bad = 0;
    int len = 4 * (st(d) + 1);
    chk("retain", data_w[d], prev);
    while (valid_w[d] !== 1'b1 && n < 200) begin
      if (s_w[d] !== 2'(n / (st(d) + 1))) bad++;
      if (busy_w[d] !== 1'b1) bad++;
      n++;
      @(negedge clk);
    end
    chk("latency", n, len);
    chk("s_seq", bad, 0);
    chk("data", data_w[d], w);
    chk("s_hold", s_w[d], 3);
    chk("busy", busy_w[d], 1);
`ifdef MUX_SCAN_PARITY_EN
    chk("parity", parity_w[d], ^w);
`endif
  endtask

  task automatic hold_handshake(int d, logic [3:0] w, int hold, logic c, logic [3:0] nxt, logic poke);
    ready_v[d] = 1'b0;
    repeat (hold) begin
      start_v[d] = poke;
      cont_v[d]  = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", valid_w[d], 1);
      chk("hold_data", data_w[d], w);
      chk("hold_s", s_w[d], 3);
    end
    start_v[d] = poke;
    ready_v[d] = 1'b1;
    cont_v[d]  = c;
    word_v[d]  = nxt;
    @(negedge clk);
    ready_v[d] = 1'b0;
    start_v[d] = 1'b0;
    cont_v[d]  = 1'($urandom);
    chk("hs_valid", valid_w[d], 0);
    chk("hs_s", s_w[d], 0);
    chk("hs_busy", busy_w[d], c);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] w, nxt;
    logic       c;
    int         d, hold, vcount;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 0; cont_v[i] = 0; ready_v[i] = 0; o0_v[i] = 0;
      word_v[i] = 0; prev_w[i] = 0; age[i] = 0; prev_s[i] = 0; prev_s_busy[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_s", s_w[i], 0);
      chk("rst_data", data_w[i], 0);
      chk("rst_valid", valid_w[i], 0);
      chk("rst_busy", busy_w[i], 0);
    end

    // First start honoured at the very first edge after release.
    rst_n = 1'b1;
    start_scan(0, 4'b1010);
    scan_result(0, 4'b1010, 4'b0000);
    hold_handshake(0, 4'b1010, 5, 1'b0, 4'b0000, 1'b1);
    prev_w[0] = 4'b1010;

    start_scan(1, 4'b1010);
    scan_result(1, 4'b1010, 4'b0000);
    hold_handshake(1, 4'b1010, 0, 1'b0, 4'b0000, 1'b0);
    prev_w[1] = 4'b1010;

    start_scan(0, 4'b0110);
    scan_result(0, 4'b0110, prev_w[0]);
    hold_handshake(0, 4'b0110, 0, 1'b1, 4'b1001, 1'b0);
    scan_result(0, 4'b1001, 4'b0110);
    hold_handshake(0, 4'b1001, 1, 1'b1, 4'b0111, 1'b1);
    scan_result(0, 4'b0111, 4'b1001);
    hold_handshake(0, 4'b0111, 0, 1'b1, 4'b0101, 1'b0);
    scan_result(0, 4'b0101, 4'b0111);
    hold_handshake(0, 4'b0101, 2, 1'b0, 4'b0000, 1'b0);
    prev_w[0] = 4'b0101;

    for (int it = 0; it < 10; it++) begin
      d = int'($urandom_range(0, 1));
      w = 4'($urandom);
      start_scan(d, w);
      scan_result(d, w, prev_w[d]);
      for (int k = 0; k < 3; k++) begin
        hold = int'($urandom_range(0, 4));
        c    = (k == 2) ? 1'b0 : 1'($urandom);
        nxt  = 4'($urandom);
        hold_handshake(d, w, hold, c, nxt, 1'($urandom));
        prev_w[d] = w;
        if (!c) break;
        w = nxt;
        scan_result(d, w, prev_w[d]);
      end
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    // Reset while dut0 samples select leg 2 aborts the scan for good.
    start_scan(0, 4'b1111);
    repeat (2) @(negedge clk);
    chk("pre_rst_s", s_w[0], 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_s", s_w[0], 0);
    chk("arst_valid", valid_w[0], 0);
    chk("arst_data", data_w[0], 0);
    chk("arst_busy", busy_w[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    repeat (16) begin
      @(negedge clk);
      if (valid_w[0] || busy_w[0]) vcount++;
    end
    chk("post_rst_idle", vcount, 0);
    prev_w[0] = 4'b0000;

    start_scan(0, 4'b1100);
    scan_result(0, 4'b1100, prev_w[0]);
    hold_handshake(0, 4'b1100, 1, 1'b0, 4'b0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 0, range 0..7: extra wait cycles after each select change before O0 is sampled.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request one scan; sampled only in IDLE.
REQ-005 cont  input  1  continuous mode; sampled at output handshake.
REQ-006 O0  input  1  output of the downstream 4:1 mux being scanned.
REQ-007 S  output  2  mux select driven to the 4:1 mux.
REQ-008 data  output  4  assembled word; bit i = O0 captured while S = i.
REQ-009 valid  output  1  data available.
REQ-010 ready  input  1  consumer accepts data when valid & ready.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 FSM states SHALL be IDLE, SETTLE, SAMPLE, HOLD.
REQ-013 IDLE: start=1 at an edge -> S=0; next state SETTLE if SETTLE>0, else SAMPLE.
REQ-014 SETTLE: wait counter loads SETTLE on each S change; decrements once per cycle; at 0 -> SAMPLE.
REQ-015 SAMPLE: one cycle; at its closing edge data[S] <= O0; if S<3, S <= S+1 and next is SETTLE/SAMPLE per REQ-013; if S=3, next is HOLD with valid=1.
REQ-016 Timing: start sampled at edge k -> valid high after edge k+4*(SETTLE+1); each select value driven for SETTLE+1 cycles; O0 sampled at the last edge of that window.
REQ-017 HOLD: valid, data, S (=3) stable until valid & ready at an edge.
REQ-018 Handshake edge with cont=1 -> valid=0, S=0, new scan begins (no IDLE cycle); with cont=0 -> valid=0, S=0, IDLE.
REQ-019 start outside IDLE SHALL be ignored; start and handshake in same cycle follows REQ-018 only.
REQ-020 data bits not yet re-sampled in a new scan retain prior values; data is meaningful only while valid=1.
REQ-021 cont changes outside the handshake edge SHALL have no effect.
REQ-022 busy = (state != IDLE), combinational from state register.

Reset
REQ-023 rst_n=0 SHALL immediately force: state IDLE, S=0, data=0, valid=0, busy=0, wait counter=0, parity=0 (if present).
REQ-024 Reset asserted mid-scan or in HOLD SHALL abort and discard the scan; no valid pulse follows reset release without a new start.
REQ-025 First start honoured at the first rising edge with rst_n=1.

Configuration
REQ-026 Macro MUX_SCAN_PARITY_EN defined: extra output parity (1 bit) = XOR of data[3:0], registered, updated at the same edge valid rises, stable in HOLD.
REQ-027 Macro undefined: parity port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 SETTLE=0, O0 driven as mux of constants {I3..I0}=4'b1010 by S, start pulse at edge k -> S = 0,1,2,3 in cycles k..k+3, valid=1 after edge k+4, data=4'b1010, busy=1 until handshake.
REQ-029 SETTLE=2, same stimulus -> each S value held 3 cycles, valid after edge k+12, data=4'b1010; O0 glitches in first 2 cycles of each window not captured.
REQ-030 ready=0 for 5 cycles in HOLD -> valid, data, S=3 stable; ready=1, cont=0 -> valid=0, S=0, busy=0 next cycle.
REQ-031 cont=1, ready=1, inputs 4'b0110 then 4'b1001 -> back-to-back scans, valid pulses 4 cycles apart (SETTLE=0), data 4'b0110 then 4'b1001.
REQ-032 rst_n low during SAMPLE with S=2 -> S=0, valid=0, data=0 immediately; no valid without new start.
REQ-033 MUX_SCAN_PARITY_EN defined, data=4'b0111 -> parity=1 with valid; data=4'b0101 -> parity=0.
